multicycle_ctrl: RTL and testbench

- Multi-cycle control sequencer for the single-cycle RV32 data_path, retimed into FETCH/DECODE/EXEC/MEM/WB phases so the datapath can use a data memory with variable latency.
- Consumes opcode/funct3/funct7 from the datapath and drives its reg_write, mem2reg, alu_src, mem_write, mem_read and alu_cc inputs.
- Also drives PC-advance and instruction-latch enables.
- Halts in a trap state on an unsupported instruction.

---
 rtl/multicycle_ctrl_pkg.sv | 36 +++
 rtl/multicycle_ctrl_if.sv | 32 +++
 rtl/multicycle_ctrl_alu_decoder.sv | 47 ++++
 rtl/multicycle_ctrl.sv | 142 ++++++++++++++
 tb/tb_multicycle_ctrl.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/multicycle_ctrl_pkg.sv
// multicycle_ctrl_pkg: shared types, opcode/ALU constants and instruction classifier for multicycle_ctrl
package multicycle_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
    } state_t;

    typedef enum logic [2:0] {
        CL_R, CL_I, CL_LOAD, CL_STORE, CL_BAD
    } iclass_t;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [2:0] F3_WORD  = 3'b010;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_XOR = 4'b0011;
    localparam logic [3:0] ALU_SLL = 4'b0100;
    localparam logic [3:0] ALU_SRL = 4'b0101;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_SRA = 4'b1000;

    // Only word-sized loads/stores are supported; other widths fall into CL_BAD.
    function automatic iclass_t classify(input logic [6:0] op, input logic [2:0] f3);
        return op == OP_R ? CL_R :
               op == OP_I ? CL_I :
               (op == OP_LOAD  && f3 == F3_WORD) ? CL_LOAD :
               (op == OP_STORE && f3 == F3_WORD) ? CL_STORE : CL_BAD;
    endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// multicycle_ctrl_if: controller <-> datapath bundle
//   master (controller): in opcode/funct3/funct7/mem_ready, out ir_en/pc_en/reg_write/mem2reg/
//                        alu_src/mem_read/mem_write/alu_cc/illegal/mem_fault
//   slave  (datapath):   the mirror image
interface multicycle_ctrl_if #(
    parameter int ALU_CC_W = 4
);
    logic [6:0]          opcode;
    logic [2:0]          funct3;
    logic [6:0]          funct7;
    logic                mem_ready;
    logic                ir_en;
    logic                pc_en;
    logic                reg_write;
    logic                mem2reg;
    logic                alu_src;
    logic                mem_read;
    logic                mem_write;
    logic [ALU_CC_W-1:0] alu_cc;
    logic                illegal;
    logic                mem_fault;

    modport master (
        input  opcode, funct3, funct7, mem_ready,
        output ir_en, pc_en, reg_write, mem2reg, alu_src, mem_read, mem_write, alu_cc, illegal, mem_fault
    );

    modport slave (
        output opcode, funct3, funct7, mem_ready,
        input  ir_en, pc_en, reg_write, mem2reg, alu_src, mem_read, mem_write, alu_cc, illegal, mem_fault
    );
endinterface

// File: rtl/multicycle_ctrl_alu_decoder.sv
// multicycle_ctrl_alu_decoder: {class, funct3, funct7} -> {alu_cc, illegal_op}, purely combinational
//   cls: instruction class, funct3/funct7: instruction fields
//   alu_cc: ALU operation, illegal_op: encoding not supported
import multicycle_ctrl_pkg::*;

module multicycle_ctrl_alu_decoder #(
    parameter int ALU_CC_W = 4
) (
    input  iclass_t             cls,
    input  logic [2:0]          funct3,
    input  logic [6:0]          funct7,
    output logic [ALU_CC_W-1:0] alu_cc,
    output logic                illegal_op
);
    logic       f7_zero;
    logic       f7_alt;
    logic       is_alu;
    logic [3:0] cc;

    always_comb begin
        f7_zero    = funct7 == 7'b0000000;
        f7_alt     = funct7 == 7'b0100000;
        is_alu     = cls == CL_R || cls == CL_I;
        cc         = ALU_ADD;
        illegal_op = cls == CL_BAD;
        if (is_alu) begin
            case (funct3)
                3'b000:  cc = (cls == CL_R && f7_alt) ? ALU_SUB : ALU_ADD;
                3'b001:  cc = ALU_SLL;
                3'b010:  cc = ALU_SLT;
                3'b100:  cc = ALU_XOR;
                3'b101:  cc = funct7[5] ? ALU_SRA : ALU_SRL;
                3'b110:  cc = ALU_OR;
                3'b111:  cc = ALU_AND;
                default: cc = ALU_ADD;
            endcase
            // The alternate funct7 is only meaningful for SUB/SRA; I-type immediates
            // only carry a funct7 field on the shift encodings.
            illegal_op = funct3 == 3'b011 ||
                (cls == CL_R && !(f7_zero || (f7_alt && (funct3 == 3'b000 || funct3 == 3'b101)))) ||
                (cls == CL_I && (funct3 == 3'b001 || funct3 == 3'b101) &&
                 !(f7_zero || (f7_alt && funct3 == 3'b101)));
        end
    end

    assign alu_cc = ALU_CC_W'(cc);
endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: FETCH/DECODE/EXEC/MEM/WB sequencer for the RV32 datapath with variable-latency memory
//   clk:   rising-edge clock
//   reset: asynchronous active-low reset
//   bus:   multicycle_ctrl_if.master (instruction fields and mem_ready in, datapath strobes/flags out)
// Optional: define MULTICYCLE_CTRL_MEM_TIMEOUT_EN to trap after MEM_TIMEOUT MEM cycles without mem_ready.
import multicycle_ctrl_pkg::*;

module multicycle_ctrl #(
    parameter int ALU_CC_W    = 4,
    parameter int MEM_TIMEOUT = 16
) (
    input logic               clk,
    input logic               reset,
    multicycle_ctrl_if.master bus
);
    state_t              state;
    state_t              state_nx;
    logic [6:0]          op_q;
    logic [2:0]          f3_q;
    logic [6:0]          f7_q;
    logic [6:0]          op_s;
    logic [2:0]          f3_s;
    logic [6:0]          f7_s;
    iclass_t             cls;
    logic [ALU_CC_W-1:0] dec_cc;
    logic                dec_bad;
    logic                illegal_q;
    logic                timeout;

    if (MEM_TIMEOUT < 1) begin : g_bad_cfg
        $error("MEM_TIMEOUT must be at least 1");
    end

    // DECODE sees the live instruction register; later phases use the copy captured there.
    assign op_s = state == S_DECODE ? bus.opcode : op_q;
    assign f3_s = state == S_DECODE ? bus.funct3 : f3_q;
    assign f7_s = state == S_DECODE ? bus.funct7 : f7_q;
    assign cls  = classify(op_s, f3_s);

    multicycle_ctrl_alu_decoder #(.ALU_CC_W(ALU_CC_W)) u_alu_decoder (
        .cls        (cls),
        .funct3     (f3_s),
        .funct7     (f7_s),
        .alu_cc     (dec_cc),
        .illegal_op (dec_bad)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_q      <= '0;
            f3_q      <= '0;
            f7_q      <= '0;
            illegal_q <= 1'b0;
        end else begin
            if (state == S_DECODE) begin
                op_q <= bus.opcode;
                f3_q <= bus.funct3;
                f7_q <= bus.funct7;
            end
            illegal_q <= illegal_q | (state == S_DECODE && dec_bad);
        end
    end

`ifdef MULTICYCLE_CTRL_MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
    logic [CNT_W-1:0] mem_cnt;
    logic             fault_q;

    // mem_cnt holds (MEM cycle index - 1); it is zero on the entry cycle.
    assign timeout = state == S_MEM && !bus.mem_ready && mem_cnt == CNT_W'(MEM_TIMEOUT - 1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_cnt <= '0;
            fault_q <= 1'b0;
        end else begin
            mem_cnt <= state == S_MEM ? mem_cnt + 1'b1 : '0;
            fault_q <= fault_q | timeout;
        end
    end

    assign bus.mem_fault = fault_q;
`else
    assign timeout       = 1'b0;
    assign bus.mem_fault = 1'b0;
`endif

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:   state_nx = S_FETCH;
            S_FETCH:  state_nx = S_DECODE;
            S_DECODE: state_nx = dec_bad ? S_TRAP : S_EXEC;
            S_EXEC:   state_nx = (cls == CL_LOAD || cls == CL_STORE) ? S_MEM : S_WB;
            S_MEM:    state_nx = bus.mem_ready ? (cls == CL_LOAD ? S_WB : S_FETCH) :
                                 timeout ? S_TRAP : S_MEM;
            S_WB:     state_nx = S_FETCH;
            S_TRAP:   state_nx = S_TRAP;
            default:  state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        bus.ir_en     = 1'b0;
        bus.pc_en     = 1'b0;
        bus.reg_write = 1'b0;
        bus.mem2reg   = 1'b0;
        bus.alu_src   = 1'b0;
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        bus.alu_cc    = '0;
        case (state)
            S_FETCH: bus.ir_en = 1'b1;
            S_EXEC: begin
                bus.alu_src = cls != CL_R;
                bus.alu_cc  = dec_cc;
            end
            S_MEM: begin
                bus.alu_src   = 1'b1;
                bus.alu_cc    = ALU_CC_W'(ALU_ADD);
                bus.mem_read  = cls == CL_LOAD;
                bus.mem_write = cls == CL_STORE;
                bus.pc_en     = cls == CL_STORE && bus.mem_ready;
            end
            S_WB: begin
                bus.reg_write = 1'b1;
                bus.mem2reg   = cls == CL_LOAD;
                bus.alu_src   = cls != CL_R;
                bus.alu_cc    = dec_cc;
                bus.pc_en     = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.illegal = illegal_q;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed + randomized check of multicycle_ctrl against a per-instruction phase schedule
module tb_multicycle_ctrl;
    localparam logic [3:0] C_AND = 4'd0, C_OR = 4'd1, C_ADD = 4'd2, C_XOR = 4'd3, C_SLL = 4'd4;
    localparam logic [3:0] C_SRL = 4'd5, C_SUB = 4'd6, C_SLT = 4'd7, C_SRA = 4'd8;
    localparam int K_R = 0, K_I = 1, K_LD = 2, K_ST = 3, K_BAD = 4;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    multicycle_ctrl_if #(.ALU_CC_W(4)) bus ();

    multicycle_ctrl #(.ALU_CC_W(4), .MEM_TIMEOUT(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [12:0] ev(input bit ir, input bit pc, input bit rw, input bit m2r,
                                       input bit as, input bit mr, input bit mw, input logic [3:0] cc,
                                       input bit ill, input bit mf);
        return {ir, pc, rw, m2r, as, mr, mw, cc, ill, mf};
    endfunction

    function automatic logic rb();
        return 1'($urandom);
    endfunction

    // Reference decode, written as a mnemonic table per instruction format.
    function automatic void ref_decode(input logic [31:0] ins, output int kind, output logic ok,
                                       output logic [3:0] cc);
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        op = ins[6:0];
        f3 = ins[14:12];
        f7 = ins[31:25];
        kind = K_BAD;
        ok = 1'b0;
        cc = C_ADD;
        if (op == 7'h33) begin
            kind = K_R;
            ok = 1'b1;
            case ({f7, f3})
                {7'h00, 3'd0}: cc = C_ADD;
                {7'h20, 3'd0}: cc = C_SUB;
                {7'h00, 3'd1}: cc = C_SLL;
                {7'h00, 3'd2}: cc = C_SLT;
                {7'h00, 3'd4}: cc = C_XOR;
                {7'h00, 3'd5}: cc = C_SRL;
                {7'h20, 3'd5}: cc = C_SRA;
                {7'h00, 3'd6}: cc = C_OR;
                {7'h00, 3'd7}: cc = C_AND;
                default:       ok = 1'b0;
            endcase
        end else if (op == 7'h13) begin
            kind = K_I;
            ok = 1'b1;
            case (f3)
                3'd0: cc = C_ADD;
                3'd2: cc = C_SLT;
                3'd4: cc = C_XOR;
                3'd6: cc = C_OR;
                3'd7: cc = C_AND;
                3'd1: begin cc = C_SLL; ok = f7 == 7'h00; end
                3'd5: begin cc = f7 == 7'h00 ? C_SRL : C_SRA; ok = f7 == 7'h00 || f7 == 7'h20; end
                default: ok = 1'b0;
            endcase
        end else if (op == 7'h03 && f3 == 3'd2) begin
            kind = K_LD;
            ok = 1'b1;
        end else if (op == 7'h23 && f3 == 3'd2) begin
            kind = K_ST;
            ok = 1'b1;
        end
    endfunction

    task automatic chk(input logic [12:0] exp, input string tag);
        logic [12:0] obs;
        obs = {bus.ir_en, bus.pc_en, bus.reg_write, bus.mem2reg, bus.alu_src, bus.mem_read,
               bus.mem_write, bus.alu_cc, bus.illegal, bus.mem_fault};
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b required %b", tag, obs, exp);
        end
    endtask

    task automatic step(input logic [31:0] ins, input logic mr, input logic [12:0] exp, input string tag);
        @(negedge clk);
        bus.opcode = ins[6:0];
        bus.funct3 = ins[14:12];
        bus.funct7 = ins[31:25];
        bus.mem_ready = mr;
        #1 chk(exp, tag);
    endtask

    task automatic rst_pulse();
        @(negedge clk);
        reset = 1'b0;
        #1 chk(13'd0, "rst_hold");
        @(negedge clk);
        #1 chk(13'd0, "rst_hold2");
        @(negedge clk);
        reset = 1'b1;
        #1 chk(13'd0, "idle");
    endtask

    // Walks one instruction from its FETCH cycle; n is the MEM cycle count for loads/stores.
    // Fields are scrambled after DECODE since the controller must work from its own copy.
    task automatic run_instr(input logic [31:0] ins, input int n, input string tag);
        int         kind;
        logic       ok;
        logic [3:0] cc;
        bit         as;
        ref_decode(ins, kind, ok, cc);
        as = kind != K_R;
        step(ins, rb(), ev(1, 0, 0, 0, 0, 0, 0, 4'd0, 0, 0), {tag, " fetch"});
        step(ins, rb(), 13'd0, {tag, " decode"});
        if (!ok) begin
            for (int i = 0; i < 3; i++)
                step($urandom, rb(), ev(0, 0, 0, 0, 0, 0, 0, 4'd0, 1, 0), {tag, " trap"});
            rst_pulse();
            return;
        end
        step($urandom, rb(), ev(0, 0, 0, 0, as, 0, 0, cc, 0, 0), {tag, " exec"});
        if (kind == K_R || kind == K_I) begin
            step($urandom, rb(), ev(0, 1, 1, 0, as, 0, 0, cc, 0, 0), {tag, " wb"});
        end else begin
            for (int i = 1; i <= n; i++)
                step($urandom, i == n, ev(0, kind == K_ST && i == n, 0, 0, 1, kind == K_LD, kind == K_ST,
                     C_ADD, 0, 0), {tag, " mem"});
            if (kind == K_LD)
                step($urandom, rb(), ev(0, 1, 1, 1, 1, 0, 0, C_ADD, 0, 0), {tag, " wb"});
        end
    endtask

    initial begin
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        int         sel;
        bus.opcode = '0;
        bus.funct3 = '0;
        bus.funct7 = '0;
        bus.mem_ready = 1'b0;
        rst_pulse();
        run_instr(32'h002081B3, 0, "add");
        run_instr(32'h40208133, 0, "sub");
        run_instr(32'h4020D133, 0, "sra");
        run_instr(32'h4010D093, 0, "srai");
        run_instr(32'h00209093, 0, "slli");
        run_instr(32'h0000A083, 4, "lw");
        run_instr(32'h0020A023, 1, "sw");
        run_instr(32'h022081B3, 0, "mul_illegal");
        run_instr(32'h000010B7, 0, "lui_illegal");
        run_instr(32'h0020B1B3, 0, "sltu_illegal");
        run_instr(32'h0000A083, 1, "lw1");
        // Reset in the second cycle of a stalled store MEM phase.
        step(32'h0020A023, 1'b0, ev(1, 0, 0, 0, 0, 0, 0, 4'd0, 0, 0), "swr fetch");
        step(32'h0020A023, 1'b1, 13'd0, "swr decode");
        step($urandom, 1'b1, ev(0, 0, 0, 0, 1, 0, 0, C_ADD, 0, 0), "swr exec");
        step($urandom, 1'b0, ev(0, 0, 0, 0, 1, 0, 1, C_ADD, 0, 0), "swr mem1");
        step($urandom, 1'b0, ev(0, 0, 0, 0, 1, 0, 1, C_ADD, 0, 0), "swr mem2");
        #1 reset = 1'b0;
        #1 chk(13'd0, "swr async_drop");
        rst_pulse();
        run_instr(32'h002081B3, 0, "add_after_rst");
`ifdef MULTICYCLE_CTRL_MEM_TIMEOUT_EN
        run_instr(32'h0000A083, 16, "lw_t16");
        step(32'h0020A023, 1'b0, ev(1, 0, 0, 0, 0, 0, 0, 4'd0, 0, 0), "swt fetch");
        step(32'h0020A023, 1'b0, 13'd0, "swt decode");
        step($urandom, 1'b0, ev(0, 0, 0, 0, 1, 0, 0, C_ADD, 0, 0), "swt exec");
        for (int i = 0; i < 16; i++)
            step($urandom, 1'b0, ev(0, 0, 0, 0, 1, 0, 1, C_ADD, 0, 0), "swt mem");
        step($urandom, rb(), ev(0, 0, 0, 0, 0, 0, 0, 4'd0, 0, 1), "swt trap");
        step($urandom, rb(), ev(0, 0, 0, 0, 0, 0, 0, 4'd0, 0, 1), "swt trap2");
        rst_pulse();
`endif
        for (int t = 0; t < 60; t++) begin
            sel = $urandom_range(0, 9);
            op = sel < 3 ? 7'h33 : sel < 6 ? 7'h13 : sel == 6 ? 7'h03 : sel == 7 ? 7'h23 : 7'($urandom);
            f3 = ((sel == 6 || sel == 7) && $urandom_range(0, 3) != 0) ? 3'd2 : 3'($urandom);
            f7 = $urandom_range(0, 3) == 0 ? 7'($urandom) : ($urandom_range(0, 1) != 0 ? 7'h20 : 7'h00);
            run_instr({f7, 10'($urandom), f3, 5'($urandom), op}, $urandom_range(1, 5), "rand");
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
